// File: rtl/stream_framer_pkg.sv
// Shared definitions for stream_framer: register word addresses,
// CTRL register bit positions and the framing FSM state encoding.
package stream_framer_pkg;

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_STATUS    = 8'h01;
    localparam logic [7:0] ADDR_FRAME_CNT = 8'h02;
    localparam logic [7:0] ADDR_ZERO_CNT  = 8'h03;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_FLUSH_BIT = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_e;

endpackage

// File: rtl/stream_framer_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   flush_i            empties the FIFO; push/pop in the same cycle are dropped
//   push_i, wdata_i    write strobe/data, ignored while full
//   pop_i, rdata_o     read strobe, head entry (valid while not empty)
//   full_o, empty_o    status flags
//   count_o            number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)
                count_q <= count_q + 1'b1;
            else if (do_pop && !do_push)
                count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/stream_framer.sv
// stream_framer: pairs a stream of data beats with a stream of frame
// lengths and emits framed beats with an end-of-frame marker.
// Ports:
//   CLK, RST_N                         clock, synchronous active-low reset
//   din_value/din_en/din_rdy           data beat input
//   len_value/len_en/len_rdy           frame length input (in beats)
//   dout_value/dout_last/dout_rdy/dout_en  framed output, popped by dout_en
//   cfg_address/cfg_data_in/cfg_op/cfg_en/cfg_data_out/cfg_rdy
//                                      register port (CTRL, STATUS, counters)
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned DATA_DEPTH = 16,
    parameter int unsigned LEN_DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] din_value,
    input  logic              din_en,
    output logic              din_rdy,
    input  logic [LEN_W-1:0]  len_value,
    input  logic              len_en,
    output logic              len_rdy,
    output logic [DATA_W-1:0] dout_value,
    output logic              dout_last,
    output logic              dout_rdy,
    input  logic              dout_en,
    input  logic [7:0]        cfg_address,
    input  logic [31:0]       cfg_data_in,
    input  logic              cfg_op,
    input  logic              cfg_en,
    output logic [31:0]       cfg_data_out,
    output logic              cfg_rdy
);

    localparam int unsigned DCW = $clog2(DATA_DEPTH) + 1;
    localparam int unsigned LCW = $clog2(LEN_DEPTH) + 1;

    state_e          state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic            ctrl_en_q, ctrl_en_d;
    logic [31:0]     frame_cnt_q, frame_cnt_d;
    logic [31:0]     zero_cnt_q, zero_cnt_d;

    logic            data_full, data_empty, len_full, len_empty;
    logic [DCW-1:0]  data_count;
    logic [LCW-1:0]  len_count;
    logic [LEN_W-1:0] len_head;
    logic            len_pop, data_pop;
    logic            frame_inc, zero_inc;
    logic            cfg_wr, flush;
    logic [7:0]      data_occ, len_occ;
    logic            unused_cfg_bits;

    assign cfg_rdy  = RST_N;
    assign din_rdy  = !data_full;
    assign len_rdy  = !len_full;
    assign cfg_wr   = cfg_en && cfg_op && cfg_rdy;
    assign flush    = cfg_wr && (cfg_address == ADDR_CTRL) && cfg_data_in[CTRL_FLUSH_BIT];
    assign data_pop = dout_en && dout_rdy;
    assign data_occ = 8'(data_count);
    assign len_occ  = 8'(len_count);
    assign unused_cfg_bits = ^cfg_data_in[31:2];

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .flush_i (flush),
        .push_i  (din_en),
        .wdata_i (din_value),
        .pop_i   (data_pop),
        .rdata_o (dout_value),
        .full_o  (data_full),
        .empty_o (data_empty),
        .count_o (data_count)
    );

    sync_fifo #(.WIDTH(LEN_W), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .flush_i (flush),
        .push_i  (len_en),
        .wdata_i (len_value),
        .pop_i   (len_pop),
        .rdata_o (len_head),
        .full_o  (len_full),
        .empty_o (len_empty),
        .count_o (len_count)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            ctrl_en_q   <= 1'b1;
            frame_cnt_q <= '0;
            zero_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ctrl_en_q   <= ctrl_en_d;
            frame_cnt_q <= frame_cnt_d;
            zero_cnt_q  <= zero_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        len_pop     = 1'b0;
        dout_rdy    = 1'b0;
        dout_last   = 1'b0;
        frame_inc   = 1'b0;
        zero_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // EN only gates taking a new length; a running frame completes.
                if (ctrl_en_q && !len_empty) begin
                    len_pop = 1'b1;
                    if (len_head == '0) begin
                        zero_inc = 1'b1;
                    end else begin
                        remaining_d = len_head;
                        state_d     = ST_FRAME;
                    end
                end
            end
            ST_FRAME: begin
                dout_rdy  = !data_empty;
                dout_last = dout_rdy && (remaining_q == LEN_W'(1));
                if (dout_en && dout_rdy) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        frame_inc = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush wins over any pop in the same cycle; nothing is counted.
        if (flush) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            frame_inc   = 1'b0;
            zero_inc    = 1'b0;
        end
    end

    // Counter clear takes priority over a same-cycle increment.
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        frame_cnt_d = frame_inc ? frame_cnt_q + 32'd1 : frame_cnt_q;
        zero_cnt_d  = zero_inc  ? zero_cnt_q  + 32'd1 : zero_cnt_q;
        if (cfg_wr) begin
            case (cfg_address)
                ADDR_CTRL:      ctrl_en_d   = cfg_data_in[CTRL_EN_BIT];
                ADDR_FRAME_CNT: frame_cnt_d = '0;
                ADDR_ZERO_CNT:  zero_cnt_d  = '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        cfg_data_out = '0;
        if (cfg_en && !cfg_op) begin
            case (cfg_address)
                ADDR_CTRL:      cfg_data_out = {31'd0, ctrl_en_q};
                ADDR_STATUS:    cfg_data_out = {8'd0, len_occ, data_occ, 7'd0, (state_q == ST_FRAME)};
                ADDR_FRAME_CNT: cfg_data_out = frame_cnt_q;
                ADDR_ZERO_CNT:  cfg_data_out = zero_cnt_q;
                default:        cfg_data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_framer.sv
module tb_stream_framer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  din_value;
    logic        din_en;
    logic        din_rdy;
    logic [7:0]  len_value;
    logic        len_en;
    logic        len_rdy;
    logic [7:0]  dout_value;
    logic        dout_last;
    logic        dout_rdy;
    logic        dout_en;
    logic [7:0]  cfg_address;
    logic [31:0] cfg_data_in;
    logic        cfg_op;
    logic        cfg_en;
    logic [31:0] cfg_data_out;
    logic        cfg_rdy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0]  vals  [8];
    logic        lasts [8];
    int          got;
    int          max_gap;
    logic [31:0] rd;

    always #10 CLK = ~CLK;

    stream_framer #(
        .DATA_W(8), .LEN_W(8), .DATA_DEPTH(16), .LEN_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
        .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
        .dout_value(dout_value), .dout_last(dout_last), .dout_rdy(dout_rdy), .dout_en(dout_en),
        .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op), .cfg_en(cfg_en),
        .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_data(input logic [7:0] d);
        din_value = d;
        din_en    = 1'b1;
        tick();
        din_en    = 1'b0;
    endtask

    task automatic push_len(input logic [7:0] l);
        len_value = l;
        len_en    = 1'b1;
        tick();
        len_en    = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_address = a;
        cfg_data_in = d;
        cfg_op      = 1'b1;
        cfg_en      = 1'b1;
        tick();
        cfg_en      = 1'b0;
        cfg_op      = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        cfg_address = a;
        cfg_op      = 1'b0;
        cfg_en      = 1'b1;
        #1;
        d = cfg_data_out;
        cfg_en = 1'b0;
    endtask

    // Holds dout_en high until n beats are seen or the cycle budget runs out.
    task automatic collect(input int n, output int n_got, output int gap_max);
        int gap = 0;
        bit started = 1'b0;
        n_got   = 0;
        gap_max = 0;
        dout_en = 1'b1;
        for (int c = 0; c < 100 && n_got < n; c++) begin
            if (dout_rdy) begin
                vals[n_got]  = dout_value;
                lasts[n_got] = dout_last;
                n_got++;
                if (started && gap > gap_max) gap_max = gap;
                gap = 0;
                started = 1'b1;
            end else if (started) begin
                gap++;
            end
            tick();
        end
        dout_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        RST_N = 1'b0; din_value = '0; din_en = 1'b0; len_value = '0; len_en = 1'b0;
        dout_en = 1'b0; cfg_address = '0; cfg_data_in = '0; cfg_op = 1'b0; cfg_en = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();

        // Post-reset outputs
        chk("rst_din_rdy",   {31'd0, din_rdy},   32'd1);
        chk("rst_len_rdy",   {31'd0, len_rdy},   32'd1);
        chk("rst_cfg_rdy",   {31'd0, cfg_rdy},   32'd1);
        chk("rst_dout_rdy",  {31'd0, dout_rdy},  32'd0);
        chk("rst_dout_last", {31'd0, dout_last}, 32'd0);
        chk("rst_cfg_out",   cfg_data_out,       32'd0);
        cfg_read(8'h00, rd); chk("rst_ctrl", rd, 32'd1);
        cfg_read(8'h01, rd); chk("rst_status", rd, 32'd0);
        tick();

        // Single 3-beat frame
        push_data(8'hA1); push_data(8'hA2); push_data(8'hA3);
        push_len(8'd3);
        collect(3, got, max_gap);
        chk("f1_count", got, 3);
        chk("f1_v0", {24'd0, vals[0]}, 32'hA1); chk("f1_l0", {31'd0, lasts[0]}, 0);
        chk("f1_v1", {24'd0, vals[1]}, 32'hA2); chk("f1_l1", {31'd0, lasts[1]}, 0);
        chk("f1_v2", {24'd0, vals[2]}, 32'hA3); chk("f1_l2", {31'd0, lasts[2]}, 1);
        chk("f1_idle_rdy", {31'd0, dout_rdy}, 0);
        cfg_read(8'h02, rd); chk("f1_frame_cnt", rd, 32'd1);
        tick();

        // Zero-length frame then a 1-beat frame
        push_len(8'd0); push_len(8'd1); push_data(8'h55);
        collect(1, got, max_gap);
        chk("f2_count", got, 1);
        chk("f2_v0", {24'd0, vals[0]}, 32'h55); chk("f2_l0", {31'd0, lasts[0]}, 1);
        cfg_read(8'h03, rd); chk("f2_zero_cnt", rd, 32'd1);
        cfg_read(8'h02, rd); chk("f2_frame_cnt", rd, 32'd2);
        tick();

        // Fill data FIFO, overflow push ignored, then flush
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("full_rdy_before", {31'd0, din_rdy}, 1);
            push_data(8'h60 + 8'(i));
        end
        chk("full_rdy_after", {31'd0, din_rdy}, 0);
        push_data(8'hEE);
        cfg_read(8'h01, rd); chk("full_status", rd, 32'h0000_1000);
        tick();
        cfg_write(8'h00, 32'h3);
        cfg_read(8'h01, rd); chk("flush_status", rd, 32'd0);
        cfg_read(8'h00, rd); chk("flush_ctrl_selfclr", rd, 32'd1);
        cfg_read(8'h02, rd); chk("flush_cnt_kept", rd, 32'd2);
        chk("flush_din_rdy", {31'd0, din_rdy}, 1);
        tick();

        // EN=0 holds the queued length until re-enabled
        cfg_write(8'h00, 32'h0);
        push_len(8'd2); push_data(8'h11); push_data(8'h22);
        seen = 0;
        dout_en = 1'b1;
        repeat (5) begin
            if (dout_rdy) seen++;
            tick();
        end
        dout_en = 1'b0;
        chk("dis_no_output", seen, 0);
        cfg_read(8'h01, rd); chk("dis_status", rd, 32'h0001_0200);
        tick();
        cfg_write(8'h00, 32'h1);
        collect(2, got, max_gap);
        chk("en_count", got, 2);
        chk("en_v0", {24'd0, vals[0]}, 32'h11); chk("en_l0", {31'd0, lasts[0]}, 0);
        chk("en_v1", {24'd0, vals[1]}, 32'h22); chk("en_l1", {31'd0, lasts[1]}, 1);
        cfg_read(8'h02, rd); chk("en_frame_cnt", rd, 32'd3);
        tick();

        // Flush mid-frame after one of four beats
        push_data(8'hB1); push_data(8'hB2); push_data(8'hB3); push_data(8'hB4);
        push_len(8'd4);
        collect(1, got, max_gap);
        chk("mid_v0", {24'd0, vals[0]}, 32'hB1);
        chk("mid_rdy_pre", {31'd0, dout_rdy}, 1);
        cfg_write(8'h00, 32'h3);
        chk("mid_rdy_post", {31'd0, dout_rdy}, 0);
        cfg_read(8'h01, rd); chk("mid_status", rd, 32'd0);
        cfg_read(8'h02, rd); chk("mid_frame_cnt", rd, 32'd3);
        tick();

        // Back-to-back 2-beat frames
        push_data(8'hC1); push_data(8'hC2); push_data(8'hC3); push_data(8'hC4);
        push_len(8'd2); push_len(8'd2);
        collect(4, got, max_gap);
        chk("b2b_count", got, 4);
        chk("b2b_gap_le1", {31'd0, (max_gap <= 1)}, 1);
        chk("b2b_v0", {24'd0, vals[0]}, 32'hC1); chk("b2b_l0", {31'd0, lasts[0]}, 0);
        chk("b2b_v1", {24'd0, vals[1]}, 32'hC2); chk("b2b_l1", {31'd0, lasts[1]}, 1);
        chk("b2b_v2", {24'd0, vals[2]}, 32'hC3); chk("b2b_l2", {31'd0, lasts[2]}, 0);
        chk("b2b_v3", {24'd0, vals[3]}, 32'hC4); chk("b2b_l3", {31'd0, lasts[3]}, 1);
        cfg_read(8'h02, rd); chk("b2b_frame_cnt", rd, 32'd5);
        tick();

        // Counter clears, unmapped address, read data gated by op
        cfg_write(8'h02, 32'hDEAD);
        cfg_read(8'h02, rd); chk("clr_frame_cnt", rd, 32'd0);
        cfg_write(8'h03, 32'h7);
        cfg_read(8'h03, rd); chk("clr_zero_cnt", rd, 32'd0);
        cfg_write(8'h10, 32'hFFFF);
        cfg_read(8'h10, rd); chk("unmapped_read", rd, 32'd0);
        cfg_read(8'h00, rd); chk("ctrl_after_unmapped", rd, 32'd1);
        cfg_address = 8'h00; cfg_op = 1'b1; cfg_en = 1'b0;
        #1;
        chk("read_gated_idle", cfg_data_out, 32'd0);
        cfg_op = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 Parameter DATA_W, default 8, width of data beats.
REQ-002 Parameter LEN_W, default 8, width of frame length in beats.
REQ-003 Parameter DATA_DEPTH, default 16, data FIFO entries; power of two, minimum 2.
REQ-004 Parameter LEN_DEPTH, default 4, length FIFO entries; power of two, minimum 2.
REQ-005 CLK  in  1  single clock; all logic on its rising edge.
REQ-006 RST_N  in  1  reset; synchronous, active-low.
REQ-007 din_value  in  DATA_W  data beat; din_en in 1, push strobe; din_rdy out 1, data FIFO can accept.
REQ-008 len_value  in  LEN_W  frame length; len_en in 1, push strobe; len_rdy out 1, length FIFO can accept.
REQ-009 dout_value  out  DATA_W  head data beat; dout_last out 1, final beat of the frame; dout_rdy out 1, beat valid; dout_en in 1, pop strobe.
REQ-010 cfg_address  in  8  register word address; cfg_data_in in 32, write data; cfg_op in 1, 1=write, 0=read; cfg_en in 1, access strobe.
REQ-011 cfg_data_out  out  32  read data; cfg_rdy out 1, register port ready.

Function
REQ-012 Every strobe is honoured only when its rdy is high in the same cycle; a strobe while rdy is low is ignored with no state change.
REQ-013 din_rdy = data FIFO not full; len_rdy = length FIFO not full; cfg_rdy = 1 outside reset.
REQ-014 FSM states are IDLE and FRAME.
REQ-015 IDLE: when CTRL.EN=1 and the length FIFO is non-empty, pop one length L; L=0 increments ZERO_CNT and stays IDLE; L>0 loads remaining=L and moves to FRAME next cycle.
REQ-016 FRAME: dout_rdy = data FIFO non-empty; dout_value = FIFO head; dout_last = (remaining==1) and dout_rdy.
REQ-017 dout_en pops one beat and decrements remaining; a pop with remaining==1 increments FRAME_CNT and returns to IDLE.
REQ-018 dout_rdy and dout_last are 0 in IDLE.
REQ-019 Back-to-back frames: at most one idle cycle between the last beat of one frame and the first beat of the next.
REQ-020 A simultaneous push and pop on a FIFO that is neither full nor empty leaves its occupancy unchanged.
REQ-021 Clearing CTRL.EN mid-frame does not stop the current frame; it blocks only the next length pop.
REQ-022 A write of 1 to CTRL.FLUSH empties both FIFOs, forces IDLE and clears remaining in the following cycle; FLUSH self-clears; counters are preserved; pushes in the flush cycle are discarded.
REQ-023 Registers: 0x00 CTRL (bit0 EN RW, bit1 FLUSH W1); 0x01 STATUS RO (bit0 busy=FRAME; [15:8] data occupancy; [23:16] length occupancy); 0x02 FRAME_CNT; 0x03 ZERO_CNT; writing any value to a counter clears it.
REQ-024 Reads are combinational: cfg_data_out shows the addressed register while cfg_en=1 and cfg_op=0, otherwise 0; unmapped addresses read 0 and ignore writes.
REQ-025 A counter clear and an increment in the same cycle leave the counter at 0; counters wrap modulo 2^32.

Reset
REQ-026 While RST_N=0 on a rising edge: FIFOs empty, state IDLE, remaining 0, counters 0, CTRL.EN=1, FLUSH=0.
REQ-027 On the first edge after reset release: din_rdy=1, len_rdy=1, cfg_rdy=1, dout_rdy=0, dout_last=0, cfg_data_out=0.
REQ-028 Reset asserted mid-frame abandons the frame with no counter update.

Structure
REQ-029 Package stream_framer_pkg holds the register address constants, the CTRL bit positions and the state enum.
REQ-030 One sub-module, sync_fifo (parametrised width and depth, full/empty/count), instantiated once for data and once for lengths.

Verification
REQ-031 Reset, then push len 3 and data 0xA1,0xA2,0xA3, dout_en held high -> three beats in order, dout_last only on 0xA3, FRAME_CNT=1.
REQ-032 Push len 0 then len 1 with data 0x55 -> ZERO_CNT=1, single beat 0x55 with dout_last=1.
REQ-033 Push 16 data beats with no length -> din_rdy=0 after the 16th; 17th push is ignored; STATUS[15:8]=16.
REQ-034 Write CTRL=0, push len 2 and two beats -> dout_rdy stays 0; write CTRL=1 -> frame emitted.
REQ-035 Mid-frame (1 of 4 beats popped) write CTRL=0x3 -> next cycle dout_rdy=0, STATUS=0, FRAME_CNT unchanged.
REQ-036 Lengths 2,2 queued with data present, dout_en held high -> four beats with at most one gap, dout_last on beats 2 and 4.
